// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// Single pipeline stage with a one-entry skid buffer. The main register
// drives out_data; the skid register catches the one word that arrives
// in the cycle the downstream first stalls, so in_ready can be a pure
// decode of state flops instead of a combinational function of out_ready.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        asynchronous active-high reset
//   in_valid   upstream presents in_data
//   in_ready   stage can accept this cycle (decoded from state flops only)
//   in_data    upstream payload
//   flush      synchronous kill of all held entries, highest priority
//   out_valid  out_data is valid
//   out_ready  downstream accepts this cycle
//   out_data   payload to the next stage, NOP_VALUE when nothing is held
//   occupancy  number of held entries, 0..2
//   clr_stats  synchronous clear of stall_cnt
//   stall_cnt  saturating count of back-pressured cycles
module pipe_stage_skid #(
    parameter int                 DATA_W    = 16,
    parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}},
    parameter int                 STALL_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [1:0]         occupancy,
    input  logic               clr_stats,
    output logic [STALL_W-1:0] stall_cnt
);

    // Encoding equals the number of held entries, so occupancy is the state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [DATA_W-1:0]  main_r;
    logic [DATA_W-1:0]  main_s;
    logic [DATA_W-1:0]  skid_r;
    logic [DATA_W-1:0]  skid_s;
    logic [STALL_W-1:0] stall_r;
    logic [STALL_W-1:0] stall_s;
    logic               accept_s;
    logic               release_s;

    localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

    // Handshake outputs are decodes of the state register only.
    assign in_ready  = (state_r != ST_TWO);
    assign out_valid = (state_r != ST_EMPTY);
    assign occupancy = state_r;
    // main_r is forced to NOP_VALUE whenever the stage becomes empty, so it
    // can drive the output directly without a mux.
    assign out_data  = main_r;
    assign stall_cnt = stall_r;

    assign accept_s  = in_valid & in_ready;
    assign release_s = out_valid & out_ready;

    // State register, payload registers and stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_EMPTY;
            main_r  <= NOP_VALUE;
            skid_r  <= NOP_VALUE;
            stall_r <= {STALL_W{1'b0}};
        end else begin
            state_r <= state_s;
            main_r  <= main_s;
            skid_r  <= skid_s;
            stall_r <= stall_s;
        end
    end

    // Next-state and payload movement; flush overrides every other event.
    always_comb begin
        state_s = state_r;
        main_s  = main_r;
        skid_s  = skid_r;
        if (flush) begin
            state_s = ST_EMPTY;
            main_s  = NOP_VALUE;
            skid_s  = NOP_VALUE;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_s = ST_ONE;
                        main_s  = in_data;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && release_s) begin
                        state_s = ST_ONE;
                        main_s  = in_data;
                    end else if (accept_s) begin
                        state_s = ST_TWO;
                        skid_s  = in_data;
                    end else if (release_s) begin
                        state_s = ST_EMPTY;
                        main_s  = NOP_VALUE;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a release can happen.
                    if (release_s) begin
                        state_s = ST_ONE;
                        main_s  = skid_r;
                        skid_s  = NOP_VALUE;
                    end else begin
                        state_s = ST_TWO;
                    end
                end
                default: begin
                    state_s = ST_EMPTY;
                    main_s  = NOP_VALUE;
                    skid_s  = NOP_VALUE;
                end
            endcase
        end
    end

    // Saturating stall counter; clear beats a same-cycle increment and
    // flush deliberately has no effect on it.
    always_comb begin
        stall_s = stall_r;
        if (clr_stats) begin
            stall_s = {STALL_W{1'b0}};
        end else if (out_valid && !out_ready && (stall_r != STALL_MAX)) begin
            stall_s = stall_r + {{(STALL_W-1){1'b0}}, 1'b1};
        end else begin
            stall_s = stall_r;
        end
    end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The module SHALL provide parameter DATA_W, default 16, giving the payload width in bits.
REQ-002 The module SHALL provide parameter NOP_VALUE, default {DATA_W{1'b0}}, giving the bubble payload driven when no valid data is held.
REQ-003 The module SHALL provide parameter STALL_W, default 8, giving the stall counter width.
REQ-004 The module SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  upstream presents in_data.
REQ-008 in_ready  output  1  stage can accept this cycle; driven only from state flops.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 flush  input  1  synchronous kill of all held entries (branch mispredict / bubble insert).
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 out_ready  input  1  downstream accepts this cycle.
REQ-013 out_data  output  DATA_W  payload to the next stage.
REQ-014 occupancy  output  2  number of held entries, 0..2.
REQ-015 clr_stats  input  1  synchronous clear of stall_cnt.
REQ-016 stall_cnt  output  STALL_W  saturating count of back-pressured cycles.

Function
REQ-017 The stage SHALL hold a main register (drives out_data) and a skid register, with states EMPTY (occupancy 0), ONE (occupancy 1), TWO (occupancy 2).
REQ-018 Accept SHALL occur when in_valid & in_ready; release SHALL occur when out_valid & out_ready.
REQ-019 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO; out_valid SHALL be 1 in ONE and TWO.
REQ-020 EMPTY: accept -> ONE, main <= in_data; no accept -> stay EMPTY.
REQ-021 ONE: accept & release -> ONE, main <= in_data; accept & no release -> TWO, skid <= in_data; release & no accept -> EMPTY; neither -> stay ONE, main unchanged.
REQ-022 TWO: release -> ONE, main <= skid; no release -> stay TWO, both registers unchanged.
REQ-023 Latency SHALL be exactly 1 cycle from accept to out_valid when the stage was EMPTY; sustained throughput SHALL be 1 transfer per cycle while out_ready=1.
REQ-024 Data order SHALL be strict FIFO; no entry SHALL be dropped or duplicated absent flush.
REQ-025 When out_valid=0, out_data SHALL equal NOP_VALUE.
REQ-026 flush=1 SHALL force next state EMPTY, main and skid <= NOP_VALUE, and discard any same-cycle accept; flush SHALL take priority over every other event.
REQ-027 in_ready SHALL not depend combinationally on out_ready, flush or in_valid.
REQ-028 stall_cnt SHALL increment by 1 on each cycle with out_valid=1 & out_ready=0, saturate at all-ones, and not wrap.
REQ-029 clr_stats=1 SHALL zero stall_cnt on the next edge and take priority over a same-cycle increment.
REQ-030 flush SHALL not affect stall_cnt.

Reset
REQ-031 While rst=1, state SHALL be EMPTY, main and skid SHALL be NOP_VALUE, and stall_cnt SHALL be 0, independent of clk.
REQ-032 Reset SHALL produce in_ready=1, out_valid=0, occupancy=0 and out_data=NOP_VALUE.
REQ-033 rst asserted mid-operation in TWO SHALL discard both entries immediately.
REQ-034 After rst deasserts, the first accept SHALL be permitted on the first rising edge.

Verification
REQ-035 Streaming: out_ready=1, feed 0x0001..0x0008 back-to-back -> out_data 0x0001..0x0008 on consecutive cycles, each 1 cycle after accept; stall_cnt=0.
REQ-036 Skid fill: hold out_ready=0, offer 0xAAAA then 0xBBBB then 0xCCCC -> first two accepted, occupancy=2, in_ready=0, 0xCCCC held upstream; raise out_ready -> outputs 0xAAAA, 0xBBBB, 0xCCCC in order.
REQ-037 Flush priority: in TWO, assert flush with in_valid=1 and in_data=0x1234 -> next cycle occupancy=0, out_valid=0, out_data=NOP_VALUE, 0x1234 never appears at the output.
REQ-038 Stall saturation: STALL_W=3, out_valid=1, out_ready=0 for 10 cycles -> stall_cnt reaches 7 and holds; clr_stats pulse -> 0.
REQ-039 Async reset: in TWO, pulse rst between clock edges -> outputs go to reset values before the next edge; accept 0x00FF on the first edge after release -> out_data=0x00FF one cycle later.
REQ-040 Random bench: random in_valid, out_ready and flush with DATA_W=32 -> a scoreboard observes in-order, loss-free delivery between flushes, and in_ready never depends combinationally on out_ready.
